// File: rtl/tama_pkg.sv
// tama_pkg: shared types and constant tables for the tamagotchi display stage.
// Holds the mood and mode enums, status bit positions, the per-mood
// animation frame ROM and the 7-segment hex font.
package tama_pkg;

  // Animated moods; IDLE is shown when no status flag is set.
  typedef enum logic [3:0] {
    MOOD_IDLE   = 4'd0,
    MOOD_HAPPY  = 4'd1,
    MOOD_SAD    = 4'd2,
    MOOD_LONELY = 4'd3,
    MOOD_DIRTY  = 4'd4,
    MOOD_SLEEPY = 4'd5,
    MOOD_HUNGRY = 4'd6,
    MOOD_SICK   = 4'd7,
    MOOD_DEAD   = 4'd8
  } mood_e;

  // Display mode: animation or one of the six stat pages, in button order.
  typedef enum logic [2:0] {
    MODE_ANIM      = 3'd0,
    MODE_P_HUNGER  = 3'd1,
    MODE_P_HAPPY   = 3'd2,
    MODE_P_HEALTH  = 3'd3,
    MODE_P_HYGIENE = 3'd4,
    MODE_P_ENERGY  = 3'd5,
    MODE_P_SOCIAL  = 3'd6
  } mode_e;

  // Bit positions inside the status word.
  localparam int ST_DEAD   = 7;
  localparam int ST_SICK   = 6;
  localparam int ST_HUNGRY = 5;
  localparam int ST_SLEEPY = 4;
  localparam int ST_DIRTY  = 3;
  localparam int ST_LONELY = 2;
  localparam int ST_SAD    = 1;
  localparam int ST_HAPPY  = 0;

  // Four animation frames per mood, indexed by mood_e then frame number.
  // Segment order is {g,f,e,d,c,b,a}.
  localparam logic [6:0] FRAME_ROM [9][4] = '{
    '{7'h5C, 7'h63, 7'h5C, 7'h63},   // IDLE: eyes look down/up
    '{7'h63, 7'h5C, 7'h01, 7'h08},   // HAPPY: bounce
    '{7'h54, 7'h54, 7'h5C, 7'h5C},   // SAD
    '{7'h30, 7'h06, 7'h30, 7'h06},   // LONELY: glance left/right
    '{7'h49, 7'h36, 7'h49, 7'h36},   // DIRTY
    '{7'h5B, 7'h00, 7'h5B, 7'h00},   // SLEEPY: blinking "z"
    '{7'h3F, 7'h5C, 7'h3F, 7'h5C},   // HUNGRY: mouth open/close
    '{7'h76, 7'h49, 7'h76, 7'h49},   // SICK
    '{7'h40, 7'h40, 7'h40, 7'h40}    // DEAD: flat line, static
  };

  // Hex digit glyphs 0..F.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Highest-priority status flag selects the mood.
  function automatic mood_e mood_encode(input logic [7:0] status);
    mood_e m;
    if      (status[ST_DEAD])   m = MOOD_DEAD;
    else if (status[ST_SICK])   m = MOOD_SICK;
    else if (status[ST_HUNGRY]) m = MOOD_HUNGRY;
    else if (status[ST_SLEEPY]) m = MOOD_SLEEPY;
    else if (status[ST_DIRTY])  m = MOOD_DIRTY;
    else if (status[ST_LONELY]) m = MOOD_LONELY;
    else if (status[ST_SAD])    m = MOOD_SAD;
    else if (status[ST_HAPPY])  m = MOOD_HAPPY;
    else                        m = MOOD_IDLE;
    return m;
  endfunction

endpackage

// File: rtl/tama_if.sv
// tama_if: bundle between the core and the display stage.
// There is no valid/ready handshake here: status and stats are level inputs
// sampled every cycle, btn_next is a debounced level whose rising edge acts,
// and seg_out/dp are registered levels; frame_tick is a one-cycle pulse.
interface tama_if;
  logic [7:0] status;
  logic [3:0] hunger;
  logic [3:0] happiness;
  logic [3:0] health;
  logic [3:0] hygiene;
  logic [3:0] energy;
  logic [3:0] social;
  logic       btn_next;
  logic [6:0] seg_out;
  logic       dp;
  logic       frame_tick;

  // Core / stimulus side.
  modport master (
    output status, hunger, happiness, health, hygiene, energy, social, btn_next,
    input  seg_out, dp, frame_tick
  );

  // Display stage side.
  modport slave (
    input  status, hunger, happiness, health, hygiene, energy, social, btn_next,
    output seg_out, dp, frame_tick
  );
endinterface

// File: rtl/tama_tick.sv
// tama_tick: frame prescaler. Counts enabled clk cycles 0..TICK_DIV-1 and
// pulses frame_tick during the last count. Holds while ena is low.
module tama_tick #(
  parameter logic [23:0] TICK_DIV = 24'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic frame_tick
);

  localparam logic [23:0] LAST = TICK_DIV - 24'd1;

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;

  // Next count: wrap at the last value, hold when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      cnt_d = (cnt_q == LAST) ? 24'd0 : cnt_q + 24'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 24'd0;
    else        cnt_q <= cnt_d;
  end

  assign frame_tick = ena && (cnt_q == LAST);

endmodule

// File: rtl/tama_display.sv
// tama_display: 7-segment display stage of the tamagotchi core.
// Shows either an animated face chosen by the highest-priority status flag,
// or one stat as a hex digit on pages stepped through with btn_next.
// Optional feature macro TAMA_BLINK_EN: blink low stats (<= 2) on stat pages.
module tama_display
  import tama_pkg::*;
#(
  parameter logic [23:0] TICK_DIV = 24'd10_000_000,
  parameter logic [3:0]  AUTO_RET = 4'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  tama_if.slave      bus,
  output mode_e      dbg_mode_o,
  output mood_e      dbg_mood_o,
  output logic [1:0] dbg_frame_o,
  output logic [3:0] dbg_idle_o
);

  logic       frame_tick;
  logic       btn_q;
  logic       btn_rise;
  mood_e      mood_q, mood_d, mood_new;
  logic [1:0] frame_q, frame_d;
  mode_e      mode_q, mode_d;
  logic [3:0] idle_q, idle_d;
  logic [3:0] stat_sel;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  tama_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .frame_tick (frame_tick)
  );

  assign btn_rise = ena && bus.btn_next && !btn_q;
  assign mood_new = mood_encode(bus.status);

  // Button history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   btn_q <= 1'b0;
    else if (ena) btn_q <= bus.btn_next;
  end

  // Mood/frame next state: status is only looked at on frame ticks, so the
  // animation stays current even while a stat page is shown.
  always_comb begin
    mood_d  = mood_q;
    frame_d = frame_q;
    if (frame_tick) begin
      mood_d = mood_new;
      if (mood_new == MOOD_DEAD || mood_new != mood_q) frame_d = 2'd0;
      else                                             frame_d = frame_q + 2'd1;
    end
  end

  // Mood/frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mood_q  <= MOOD_IDLE;
      frame_q <= 2'd0;
    end else begin
      mood_q  <= mood_d;
      frame_q <= frame_d;
    end
  end

  // Mode FSM next state: a button edge advances the page and beats the
  // auto-return expiry; otherwise idle frame ticks on a page count toward it.
  always_comb begin
    mode_d = mode_q;
    idle_d = idle_q;
    if (btn_rise) begin
      idle_d = 4'd0;
      case (mode_q)
        MODE_ANIM:      mode_d = MODE_P_HUNGER;
        MODE_P_HUNGER:  mode_d = MODE_P_HAPPY;
        MODE_P_HAPPY:   mode_d = MODE_P_HEALTH;
        MODE_P_HEALTH:  mode_d = MODE_P_HYGIENE;
        MODE_P_HYGIENE: mode_d = MODE_P_ENERGY;
        MODE_P_ENERGY:  mode_d = MODE_P_SOCIAL;
        default:        mode_d = MODE_ANIM;
      endcase
    end else if (mode_q != MODE_ANIM && frame_tick) begin
      if (idle_q + 4'd1 >= AUTO_RET) begin
        mode_d = MODE_ANIM;
        idle_d = 4'd0;
      end else begin
        idle_d = idle_q + 4'd1;
      end
    end
  end

  // Mode FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_ANIM;
      idle_q <= 4'd0;
    end else begin
      mode_q <= mode_d;
      idle_q <= idle_d;
    end
  end

  // Stat shown on the current page.
  always_comb begin
    stat_sel = 4'd0;
    case (mode_q)
      MODE_P_HUNGER:  stat_sel = bus.hunger;
      MODE_P_HAPPY:   stat_sel = bus.happiness;
      MODE_P_HEALTH:  stat_sel = bus.health;
      MODE_P_HYGIENE: stat_sel = bus.hygiene;
      MODE_P_ENERGY:  stat_sel = bus.energy;
      MODE_P_SOCIAL:  stat_sel = bus.social;
      default:        stat_sel = 4'd0;
    endcase
  end

`ifdef TAMA_BLINK_EN
  logic blink_q, blink_d;

  // Blink phase: visible on page entry, toggles on every tick on a page.
  always_comb begin
    blink_d = blink_q;
    if (btn_rise)                                   blink_d = 1'b1;
    else if (mode_q != MODE_ANIM && frame_tick)     blink_d = !blink_q;
  end

  // Blink phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 1'b1;
    else        blink_q <= blink_d;
  end
`endif

  // Output mux: animation frame or hex digit with the decimal point lit.
  always_comb begin
    seg_d = 7'h00;
    dp_d  = 1'b0;
    if (mode_q == MODE_ANIM) begin
      seg_d = FRAME_ROM[mood_q][frame_q];
    end else begin
      dp_d  = 1'b1;
      seg_d = HEX_FONT[stat_sel];
`ifdef TAMA_BLINK_EN
      if (!blink_q && stat_sel <= 4'd2) seg_d = 7'h00;
`endif
    end
  end

  // Output registers; reset blanks the display at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h00;
      dp_q  <= 1'b0;
    end else if (ena) begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick;

  assign dbg_mode_o  = mode_q;
  assign dbg_mood_o  = mood_q;
  assign dbg_frame_o = frame_q;
  assign dbg_idle_o  = idle_q;

endmodule

// File: tb/tb_tama_display.sv
// tb_tama_display: directed bench for tama_display with TICK_DIV=4, AUTO_RET=3.
// cyc counts enabled clock edges since reset release; frame ticks act on
// edges where cyc is a multiple of 4. All checks sample 1 time unit after
// the rising edge.
module tb_tama_display;
  import tama_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  always #5 clk = ~clk;

  tama_if bus ();

  mode_e      dbg_mode;
  mood_e      dbg_mood;
  logic [1:0] dbg_frame;
  logic [3:0] dbg_idle;

  tama_display #(.TICK_DIV(24'd4), .AUTO_RET(4'd3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .bus         (bus),
    .dbg_mode_o  (dbg_mode),
    .dbg_mood_o  (dbg_mood),
    .dbg_frame_o (dbg_frame),
    .dbg_idle_o  (dbg_idle)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [6:0] exp_seg [0:20];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) step();
  endtask

  // One-cycle button pulse; the new page is on seg_out when this returns.
  task automatic press();
    bus.btn_next = 1'b1;
    step();
    bus.btn_next = 1'b0;
    step();
  endtask

  initial begin
    bus.status    = 8'h00;
    bus.hunger    = 4'hA;
    bus.happiness = 4'h5;
    bus.health    = 4'h2;
    bus.hygiene   = 4'hF;
    bus.energy    = 4'h0;
    bus.social    = 4'hC;
    bus.btn_next  = 1'b0;
    ena           = 1'b1;

    exp_seg = '{7'h00,
                7'h5C, 7'h5C, 7'h5C, 7'h5C,
                7'h63, 7'h63, 7'h63, 7'h63,
                7'h5C, 7'h5C, 7'h5C, 7'h5C,
                7'h63, 7'h63, 7'h63, 7'h63,
                7'h5C, 7'h5C, 7'h5C, 7'h5C};

    // Reset and release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg",   {1'b0, bus.seg_out}, 8'h00);
    check("rst_dp",    {7'd0, bus.dp}, 8'h00);
    rst_n = 1'b1;
    cyc   = 0;
    check("rst_tick",  {7'd0, bus.frame_tick}, 8'h00);
    check("rst_mode",  8'(dbg_mode), 8'(MODE_ANIM));
    check("rst_mood",  8'(dbg_mood), 8'(MOOD_IDLE));
    check("rst_frame", {6'd0, dbg_frame}, 8'h00);

    // IDLE animation and tick period.
    for (int k = 1; k <= 20; k++) begin
      step();
      check("idle_seg",  {1'b0, bus.seg_out}, {1'b0, exp_seg[k]});
      check("idle_tick", {7'd0, bus.frame_tick}, ((k % 4) == 3) ? 8'h01 : 8'h00);
    end

    // DEAD overrides HAPPY, applied only at the next tick, then static.
    bus.status = 8'h81;
    to_cycle(22);
    check("dead_wait_seg", {1'b0, bus.seg_out}, 8'h63);
    to_cycle(23);
    check("dead_wait_mood", 8'(dbg_mood), 8'(MOOD_IDLE));
    to_cycle(24);
    check("dead_mood", 8'(dbg_mood), 8'(MOOD_DEAD));
    to_cycle(25);
    check("dead_seg", {1'b0, bus.seg_out}, 8'h40);
    for (int t = 1; t <= 10; t++) begin
      to_cycle(25 + 4 * t);
      check("dead_hold_seg",   {1'b0, bus.seg_out}, 8'h40);
      check("dead_hold_frame", {6'd0, dbg_frame}, 8'h00);
    end

    // A status glitch between ticks is ignored.
    bus.status = 8'h20;
    step();
    bus.status = 8'h81;
    to_cycle(69);
    check("glitch_seg",  {1'b0, bus.seg_out}, 8'h40);
    check("glitch_mood", 8'(dbg_mood), 8'(MOOD_DEAD));

    // HAPPY: mood change restarts at frame 0.
    bus.status = 8'h01;
    to_cycle(72);
    check("happy_mood",  8'(dbg_mood), 8'(MOOD_HAPPY));
    check("happy_frame", {6'd0, dbg_frame}, 8'h00);
    to_cycle(73);
    check("happy_seg0", {1'b0, bus.seg_out}, 8'h63);
    to_cycle(77);
    check("happy_seg1", {1'b0, bus.seg_out}, 8'h5C);

    // Page cycle: 2-cycle latency from button to display.
    to_cycle(78);
    bus.btn_next = 1'b1;
    step();
    bus.btn_next = 1'b0;
    check("pg1_mode",     8'(dbg_mode), 8'(MODE_P_HUNGER));
    check("pg1_seg_lat",  {1'b0, bus.seg_out}, 8'h5C);
    check("pg1_dp_lat",   {7'd0, bus.dp}, 8'h00);
    step();
    check("pg_hunger_seg", {1'b0, bus.seg_out}, 8'h77);
    check("pg_hunger_dp",  {7'd0, bus.dp}, 8'h01);
    press();
    check("pg_happy_seg", {1'b0, bus.seg_out}, 8'h6D);
    check("pg_happy_mode", 8'(dbg_mode), 8'(MODE_P_HAPPY));
    press();
    check("pg_health_seg", {1'b0, bus.seg_out}, 8'h5B);
    press();
    check("pg_hygiene_seg", {1'b0, bus.seg_out}, 8'h71);
    press();
    check("pg_energy_seg", {1'b0, bus.seg_out}, 8'h3F);
    press();
    check("pg_social_seg", {1'b0, bus.seg_out}, 8'h39);
    check("pg_social_dp",  {7'd0, bus.dp}, 8'h01);
    press();
    check("pg_ret_mode", 8'(dbg_mode), 8'(MODE_ANIM));
    check("pg_ret_dp",   {7'd0, bus.dp}, 8'h00);
    check("pg_ret_seg",  {1'b0, bus.seg_out}, 8'h63);

    // Auto-return after 3 idle ticks; live stat update on a page.
    press();
    press();
    check("ar_mode_entry", 8'(dbg_mode), 8'(MODE_P_HAPPY));
    bus.happiness = 4'h7;
    step();
    check("live_stat_seg", {1'b0, bus.seg_out}, 8'h07);
    to_cycle(103);
    check("ar_mode_before", 8'(dbg_mode), 8'(MODE_P_HAPPY));
    check("ar_idle_before", {4'd0, dbg_idle}, 8'h02);
    to_cycle(104);
    check("ar_mode_after", 8'(dbg_mode), 8'(MODE_ANIM));
    check("ar_idle_after", {4'd0, dbg_idle}, 8'h00);
    to_cycle(105);
    check("ar_dp", {7'd0, bus.dp}, 8'h00);
    check("ar_seg", {1'b0, bus.seg_out}, 8'h63);

    // Button at the expiry cycle wins and advances the page.
    press();
    press();
    check("exp_mode_entry", 8'(dbg_mode), 8'(MODE_P_HAPPY));
    check("exp_idle_entry", {4'd0, dbg_idle}, 8'h00);
    to_cycle(119);
    check("exp_idle_pre", {4'd0, dbg_idle}, 8'h02);
    bus.btn_next = 1'b1;
    step();
    bus.btn_next = 1'b0;
    check("exp_mode", 8'(dbg_mode), 8'(MODE_P_HEALTH));
    check("exp_idle", {4'd0, dbg_idle}, 8'h00);
    step();
    check("health_seg", {1'b0, bus.seg_out}, 8'h5B);
    check("health_dp",  {7'd0, bus.dp}, 8'h01);

    // Low stat on a page: blinks when the feature is built in.
    to_cycle(125);
`ifdef TAMA_BLINK_EN
    check("blink_off_seg", {1'b0, bus.seg_out}, 8'h00);
`else
    check("blink_off_seg", {1'b0, bus.seg_out}, 8'h5B);
`endif
    check("blink_dp", {7'd0, bus.dp}, 8'h01);
    to_cycle(129);
    check("blink_on_seg", {1'b0, bus.seg_out}, 8'h5B);
    bus.health = 4'h3;
    step();
    check("steady_seg0", {1'b0, bus.seg_out}, 8'h4F);
    step();
    check("steady_seg1", {1'b0, bus.seg_out}, 8'h4F);
    to_cycle(132);
    check("steady_ret_mode", 8'(dbg_mode), 8'(MODE_ANIM));
    to_cycle(133);
    check("happy_f3_seg", {1'b0, bus.seg_out}, 8'h08);
    check("happy_f3_dp",  {7'd0, bus.dp}, 8'h00);

    // Enable low freezes prescaler, frame and outputs.
    to_cycle(135);
    check("ena_pre_tick",  {7'd0, bus.frame_tick}, 8'h01);
    check("ena_pre_frame", {6'd0, dbg_frame}, 8'h03);
    ena = 1'b0;
    #1;
    check("ena_gate_tick", {7'd0, bus.frame_tick}, 8'h00);
    for (int k = 0; k < 10; k++) begin
      step();
      check("ena_hold_seg",   {1'b0, bus.seg_out}, 8'h08);
      check("ena_hold_frame", {6'd0, dbg_frame}, 8'h03);
      check("ena_hold_tick",  {7'd0, bus.frame_tick}, 8'h00);
    end
    ena = 1'b1;
    #1;
    check("ena_resume_tick", {7'd0, bus.frame_tick}, 8'h01);
    step();
    check("ena_resume_frame", {6'd0, dbg_frame}, 8'h00);
    step();
    check("ena_resume_seg", {1'b0, bus.seg_out}, 8'h63);

    // Asynchronous reset in the middle of a page.
    press();
    check("mid_page_seg", {1'b0, bus.seg_out}, 8'h77);
    check("mid_page_dp",  {7'd0, bus.dp}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_seg",  {1'b0, bus.seg_out}, 8'h00);
    check("arst_dp",   {7'd0, bus.dp}, 8'h00);
    check("arst_mode", 8'(dbg_mode), 8'(MODE_ANIM));
    check("arst_tick", {7'd0, bus.frame_tick}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tama_display.md
# tama_display

Downstream display stage of the tamagotchi core. Consumes the 8-bit `status` word and the six 4-bit stat registers and drives the 7-segment display on `uo_out[6:0]` plus the decimal point. Two display modes:
- an animated pet face whose animation is chosen from the highest-priority status flag;
- stat pages, selected with a page button, that show one stat as a hex digit.

## Interface
Parameters:
- `TICK_DIV`, 24'd10_000_000: clk cycles per animation frame tick; legal range ≥ 2.
- `AUTO_RET`, 4'd8: frame ticks without a button press before a stat page returns to animation.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ena`  in  1  design enable. When low: prescaler and all state hold, outputs hold.
- `status`  in  8  flag word: [7] dead, [6] sick, [5] hungry, [4] sleepy, [3] dirty, [2] lonely, [1] sad, [0] happy.
- `hunger`, `happiness`, `health`, `hygiene`, `energy`, `social`  in  4 each  current stat values.
- `btn_next`  in  1  debounced, synchronous level input; only a rising edge acts.
- `seg_out`  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- `dp`  out  1  decimal point, registered. High on stat pages.
- `frame_tick`  out  1  one-cycle pulse per frame, for the other stages.

## Operation
- **Prescaler**
  - `cnt` counts 0..TICK_DIV-1 and wraps to 0.
  - `frame_tick` is high in the cycle where `cnt == TICK_DIV-1` and `ena` is high.
- **Mood priority encoder** (combinational on `status`)
  - Order: DEAD > SICK > HUNGRY > SLEEPY > DIRTY > LONELY > SAD > HAPPY.
  - `status == 0` gives IDLE.
- **Mood and frame update**
  - `mood_q` is sampled only on `frame_tick`.
  - If the new mood differs from `mood_q`, `frame` is set to 0.
  - Otherwise `frame` increments modulo 4.
  - DEAD is static: `frame` is forced to 0.
- **Frame ROM**: 4 entries per mood. Required entries:
  - IDLE = 0x5C, 0x63, 0x5C, 0x63
  - HAPPY = 0x63, 0x5C, 0x01, 0x08
  - DEAD = 0x40 in all four entries
  - All other moods are defined in the package.
- **Mode FSM**
  - States: ANIM → P_HUNGER → P_HAPPY → P_HEALTH → P_HYGIENE → P_ENERGY → P_SOCIAL → ANIM.
  - The FSM advances one state per `btn_next` rising edge.
  - A rising edge resets `idle_ticks` to 0.
- **Auto-return**
  - On a stat page, `idle_ticks` increments on each `frame_tick`.
  - When `idle_ticks` reaches AUTO_RET, the FSM goes to ANIM and `idle_ticks` clears.
  - In ANIM, `idle_ticks` stays at 0.
- **Output mux**
  - ANIM: `seg_out` = ROM[`mood_q`][`frame`], `dp` = 0.
  - Stat page: `seg_out` = hex font of the selected stat, `dp` = 1.
  - Hex font: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
- **Simultaneous events**
  - A button edge and the auto-return expiry in the same cycle: the button wins and the page advances.
  - A button edge and `frame_tick` in the same cycle: both act. The mood/frame update happens even on a stat page, so the animation is current on return to ANIM.
- **Reset values**
  - Outputs: `seg_out` = 0 (blank), `dp` = 0, `frame_tick` = 0.
  - State: `cnt` = 0, mood IDLE, frame 0, mode ANIM, `idle_ticks` = 0, button history = 0.

## Timing
- `seg_out` and `dp` update on the clock edge after any change to `mood_q`, `frame`, mode, or the stat value shown.
- Latency from a `btn_next` rising edge to the new page on `seg_out` is 2 cycles: 1 cycle for edge detection, 1 cycle for the output register.
- The first `frame_tick` after reset release occurs TICK_DIV cycles after the first enabled edge.
- Changes in stat values are shown live on a stat page, with 1 cycle of latency.
- `status` changes are seen only at frame boundaries; a glitch between ticks has no effect.
- An asserted `rst_n` blanks the display immediately, including mid-frame or mid-page.

## Configuration
- `TAMA_BLINK_EN` defined: on a stat page, if the stat value ≤ 2, `seg_out` alternates between the digit and blank (0x00) on every `frame_tick`.
  - The blink phase starts visible on page entry.
  - `dp` stays lit.
- `TAMA_BLINK_EN` undefined: the digit is shown steady. No blink-phase flop is instantiated.

## Structure
- Package `tama_pkg` holds:
  - the mood enum (9 values) and the mode enum (7 values);
  - the status bit-index constants;
  - the frame ROM constant array [9][4] of 7-bit entries;
  - the hex-font constant array [16].
- Sub-module `tama_tick`: parameterised prescaler with `clk`, `rst_n`, `ena` in and `frame_tick` out. It is reused by other stages.

## Test plan
(All scenarios use TICK_DIV=4 and AUTO_RET=3 unless stated.)
1. Reset, `status`=0, run 20 cycles → `seg_out` sequence 0x00, then 0x5C, 0x63, 0x5C, 0x63 changing on each tick; `frame_tick` period is 4 cycles.
2. Set `status`=0x81 in the middle of the IDLE animation → at the next tick `seg_out`=0x40; it stays at 0x40 for 10 ticks (DEAD overrides HAPPY, static).
3. `hunger`=0xA, one `btn_next` pulse → after 2 cycles `seg_out`=0x77 and `dp`=1. Six more pulses return to ANIM with `dp`=0.
4. On page P_HAPPY with no button → exactly 3 ticks later the mode is ANIM; a press at the expiry cycle instead moves to P_HEALTH.
5. With `TAMA_BLINK_EN` defined, `health`=2 on P_HEALTH → `seg_out` alternates 0x5B/0x00 on each tick. Set `health`=3 → steady 0x4F.
6. Drop `ena` for 10 cycles mid-animation → `seg_out`, `cnt` and `frame` are frozen. Assert `rst_n` low mid-page → `seg_out`=0 and `dp`=0 asynchronously, mode is ANIM.
